// File: rtl/alu_muldiv.sv
// Multi-cycle execute-stage ALU: single-cycle RV32I register ops plus iterative
// unsigned multiply and signed/unsigned divide/remainder behind valid/ready handshakes.
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLT   = 4'd5,
        OP_SLTU  = 4'd6,
        OP_SLL   = 4'd7,
        OP_SRL   = 4'd8,
        OP_SRA   = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIVU  = 4'd12,
        OP_REMU  = 4'd13,
        OP_DIV   = 4'd14,
        OP_REM   = 4'd15
    } op_e;

    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);
    localparam logic [SHW:0] CNT_FULL = (SHW+1)'(WIDTH);

    state_e             state;
    op_e                op_q;
    logic [SHW:0]       count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd_q;
    logic               neg_q;
    logic               neg_r;

    op_e                op_in;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               is_mul_in;
    logic               is_sdiv_in;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] iter_next;
    logic [WIDTH-1:0]   fin_res;

    assign op_in     = op_e'(op);
    assign shamt     = operand_b[SHW-1:0];
    assign in_ready  = (state == S_IDLE) && !flush;
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_BUSY);

    always_comb begin
        alu_res = '0;
        case (op_in)
            OP_ADD:  alu_res = operand_a + operand_b;
            OP_SUB:  alu_res = operand_a - operand_b;
            OP_AND:  alu_res = operand_a & operand_b;
            OP_OR:   alu_res = operand_a | operand_b;
            OP_XOR:  alu_res = operand_a ^ operand_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
            OP_SLL:  alu_res = operand_a << shamt;
            OP_SRL:  alu_res = operand_a >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(operand_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // Signed divide runs on magnitudes; signs are restored in the last iteration.
    always_comb begin
        is_mul_in  = (op_in == OP_MUL) || (op_in == OP_MULHU);
        is_sdiv_in = (op_in == OP_DIV) || (op_in == OP_REM);
        a_neg      = is_sdiv_in && operand_a[WIDTH-1];
        b_neg      = is_sdiv_in && operand_b[WIDTH-1];
        a_mag      = a_neg ? ('0 - operand_a) : operand_a;
        b_mag      = b_neg ? ('0 - operand_b) : operand_b;
    end

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge   = div_sh >= {1'b0, opnd_q};
        div_diff = div_sh[WIDTH-1:0] - opnd_q;
        div_next = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

        iter_next = ((op_q == OP_MUL) || (op_q == OP_MULHU)) ? mul_next : div_next;
    end

    always_comb begin
        fin_res = '0;
        case (op_q)
            OP_MUL:         fin_res = mul_next[WIDTH-1:0];
            OP_MULHU:       fin_res = mul_next[2*WIDTH-1:WIDTH];
            OP_DIVU, OP_DIV: fin_res = neg_q ? ('0 - div_next[WIDTH-1:0]) : div_next[WIDTH-1:0];
            OP_REMU, OP_REM: fin_res = neg_r ? ('0 - div_next[2*WIDTH-1:WIDTH])
                                             : div_next[2*WIDTH-1:WIDTH];
            default:        fin_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= OP_ADD;
            count     <= '0;
            acc       <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            result    <= '0;
            zero_flag <= 1'b1;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q <= op_in;
                        if (op <= 4'd9) begin
                            result    <= alu_res;
                            zero_flag <= (alu_res == '0);
                            state     <= S_DONE;
                        end else begin
                            count <= CNT_FULL;
                            state <= S_BUSY;
                            if (is_mul_in) begin
                                opnd_q <= operand_a;
                                acc    <= {{WIDTH{1'b0}}, operand_b};
                                neg_q  <= 1'b0;
                                neg_r  <= 1'b0;
                            end else begin
                                // Divide by zero keeps an all-ones quotient regardless of signs.
                                opnd_q <= b_mag;
                                acc    <= {{WIDTH{1'b0}}, a_mag};
                                neg_q  <= (a_neg ^ b_neg) && (operand_b != '0);
                                neg_r  <= a_neg;
                            end
                        end
                    end
                end
                S_BUSY: begin
                    acc   <= iter_next;
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        result    <= fin_res;
                        zero_flag <= (fin_res == '0);
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised multi-cycle ALU for the execute stage. It covers the RV32I register-register operations plus unsigned multiply and signed/unsigned divide and remainder, and exchanges operands and results over valid/ready handshakes. Simple operations complete in one cycle; multiply and divide iterate one bit per cycle. It replaces the one-hot-select combinational ALU and adds an encoded opcode, back-pressure and a flush.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of two
- SHW, $clog2(WIDTH), shift-amount bits (derived; not overridden)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort of any in-flight or pending operation
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  block accepts a new operation
- op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL, 11 MULHU, 12 DIVU, 13 REMU, 14 DIV, 15 REM
- operand_a  in  WIDTH  first operand (dividend, multiplicand, shift source)
- operand_b  in  WIDTH  second operand (divisor, multiplier, shift amount)
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  operation result
- zero_flag  out  1  result == 0, valid with out_valid
- busy  out  1  state is BUSY

## Operation
- FSM states:
  - IDLE: in_ready = !flush. On accept (in_valid && in_ready), op and operands are captured.
    - op ≤ 9: the result is computed and the FSM moves to DONE.
    - op ≥ 10: the FSM moves to BUSY with count = WIDTH.
  - BUSY: one iteration per cycle. count decrements; at count == 1 the final fix-up is applied and the FSM moves to DONE.
  - DONE: out_valid = 1. result and zero_flag are held stable until out_ready, then the FSM moves to IDLE.
- flush: from any state, the FSM goes to IDLE next cycle, out_valid drops and no result is produced. flush in IDLE with in_valid means the operation is not accepted.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT is signed and SLTU unsigned; both give result 1 or 0, zero-extended.
  - Shifts use operand_b[SHW-1:0] only. SRA sign-fills.
- MUL is shift-add over WIDTH iterations into a 2·WIDTH accumulator. MUL returns the low half, MULHU the high half; operands are unsigned.
- DIVU/REMU use restoring division, one quotient bit per iteration.
- DIV/REM:
  - Operands are converted to magnitudes at accept.
  - In the final fix-up, the quotient is negated if the operand signs differ.
  - The remainder takes the dividend's sign.
- Division by zero is RISC-V defined: the quotient is all ones and the remainder is the dividend, sign included. It still takes the full WIDTH iterations.
- Signed overflow (DIV of the most negative value by −1): quotient = the most negative value, REM = 0.
- Operand inputs are don't-care after accept; the block relies on internal copies only.

## Timing
- Reset values:
  - state IDLE
  - in_ready 1
  - out_valid 0
  - result 0
  - zero_flag 1 (consistent with result 0)
  - busy 0
  - all internal registers 0
- Reset asserted mid-operation discards the operation immediately; there is no partial result.
- Latency, accept edge N to out_valid:
  - ops 0–9: out_valid high from N+1.
  - ops 10–15: out_valid high from N+WIDTH+1.
- Throughput: in_ready is high only in IDLE. With out_ready held high, there is one simple op per 2 cycles and one mul/div per WIDTH+2 cycles.
- out_valid with !out_ready: result, zero_flag and out_valid are held indefinitely; no new op is accepted.
- in_valid may be asserted in any state; the request is taken only when in_ready is high.
- busy is high exactly for the WIDTH BUSY cycles.

## Test plan
- Reset, then ADD 0x7FFFFFFF + 1 → result 0x80000000 one cycle after accept; then SUB 5−5 → result 0, zero_flag 1.
- SLT 0xFFFFFFFF vs 1 → 1; SLTU on the same operands → 0; SRA 0x80000000 by 0x21 (uses 1) → 0xC0000000.
- MUL 0xFFFFFFFF × 0xFFFFFFFF: low → 0x00000001, MULHU → 0xFFFFFFFE, each out_valid exactly 33 cycles after accept with busy high 32 cycles.
- Divide corner cases:
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 9/0 → 0xFFFFFFFF.
  - REMU 9/0 → 9.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000, with REM → 0.
- Back-pressure: out_ready low for 10 cycles after out_valid. Result is stable, in_ready stays 0, and a held in_valid is accepted the cycle after the handshake.
- Abort cases:
  - flush at BUSY cycle 5 of DIVU: no out_valid, IDLE next cycle.
  - rst_n pulsed low mid-MUL: all outputs at reset values, and the next op completes correctly.
